filter_mode_ctrl: RTL and testbench

- Frame-synchronous controller that sequences the per-channel colour enables feeding colour_control in the TV-decoder-to-VGA path.
- Debounces the three raw push-buttons and turns each press into a toggle of a pending (shadow) enable mask.
- Commits the pending mask to the live enables only at a VGA vertical-sync boundary, so a filter change never tears mid-frame.
- Forces pass-through (all channels on) while the TV decoder is not stable.

---
 rtl/filter_mode_ctrl.sv | 161 ++++++++++++++++
 tb/tb_filter_mode_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/filter_mode_ctrl.sv
// Frame-synchronous colour-enable controller: debounced key toggles build a shadow
// mask that is committed to the live enables only on a VGA vertical-sync falling edge.
module filter_mode_ctrl #(
   parameter int DEBOUNCE_CYCLES = 270000,
   parameter int CNT_W           = 19
) (
   input  logic       iCLK,
   input  logic       iRST_N,
   input  logic [2:0] iKEY_N,
   input  logic       iVGA_VS,
   input  logic       iTD_STABLE,
   output logic       oEN_R,
   output logic       oEN_G,
   output logic       oEN_B,
   output logic       oPENDING,
   output logic       oCOMMIT,
   output logic [7:0] oFRAME_CNT
);

   typedef enum logic [1:0] {IDLE, PENDING, COMMIT} state_t;

   localparam logic [CNT_W-1:0] LP_CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   state_t     r_state;
   state_t     w_state_next;

   logic [2:0] r_key_s1;
   logic [2:0] r_key_s2;
   logic [2:0] r_db_d;
   logic [2:0] w_db;
   logic [2:0] w_press;

   logic       r_vs_s1;
   logic       r_vs_s2;
   logic       r_vs_d;
   logic       w_vs_fall;

   logic [2:0] r_shadow;
   logic [2:0] r_live;
   logic [2:0] r_commit_mask;
   logic       r_pending;
   logic       r_commit;
   logic [7:0] r_frame_cnt;

   logic       w_snapshot;
   logic       w_apply;

   // Per-key debouncer: the level must differ from the accepted one for
   // DEBOUNCE_CYCLES consecutive cycles before it is taken.
   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_deb
         logic [CNT_W-1:0] r_cnt;
         logic             r_db;

         always_ff @(posedge iCLK or negedge iRST_N) begin
            if (!iRST_N) begin
               r_cnt <= '0;
               r_db  <= 1'b1;
            end else if (r_key_s2[gi] == r_db) begin
               r_cnt <= '0;
            end else if (r_cnt == LP_CNT_MAX) begin
               r_db  <= ~r_db;
               r_cnt <= '0;
            end else begin
               r_cnt <= r_cnt + CNT_W'(1);
            end
         end

         assign w_db[gi] = r_db;
      end
   endgenerate

   assign w_press   = r_db_d & ~w_db;
   assign w_vs_fall = r_vs_d & ~r_vs_s2;

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) r_state <= IDLE;
      else         r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      w_snapshot   = 1'b0;
      w_apply      = 1'b0;
      if (!iTD_STABLE) begin
         w_state_next = IDLE;
      end else begin
         case (r_state)
            IDLE: begin
               if (r_shadow != r_live) w_state_next = PENDING;
            end
            PENDING: begin
               if (r_shadow == r_live) begin
                  w_state_next = IDLE;
               end else if (w_vs_fall) begin
                  w_state_next = COMMIT;
                  w_snapshot   = 1'b1;
               end
            end
            COMMIT: begin
               w_apply      = 1'b1;
               w_state_next = (r_shadow != r_commit_mask) ? PENDING : IDLE;
            end
            default: w_state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         r_key_s1      <= 3'b111;
         r_key_s2      <= 3'b111;
         r_db_d        <= 3'b111;
         r_vs_s1       <= 1'b1;
         r_vs_s2       <= 1'b1;
         r_vs_d        <= 1'b1;
         r_shadow      <= 3'b111;
         r_live        <= 3'b111;
         r_commit_mask <= 3'b111;
         r_pending     <= 1'b0;
         r_commit      <= 1'b0;
         r_frame_cnt   <= 8'd0;
      end else begin
         r_key_s1 <= iKEY_N;
         r_key_s2 <= r_key_s1;
         r_db_d   <= w_db;
         r_vs_s1  <= iVGA_VS;
         r_vs_s2  <= r_vs_s1;
         r_vs_d   <= r_vs_s2;
         r_commit <= 1'b0;

         if (w_vs_fall) r_frame_cnt <= r_frame_cnt + 8'd1;

         // Unstable video: pass-through, presses dropped, pulse only on a real change.
         if (!iTD_STABLE) begin
            r_shadow      <= 3'b111;
            r_live        <= 3'b111;
            r_commit_mask <= 3'b111;
            r_pending     <= 1'b0;
            r_commit      <= (r_live != 3'b111);
         end else begin
            r_shadow  <= r_shadow ^ w_press;
            r_pending <= (r_shadow != r_live);
            if (w_snapshot) r_commit_mask <= r_shadow;
            if (w_apply) begin
               r_live   <= r_commit_mask;
               r_commit <= 1'b1;
            end
         end
      end
   end

   assign oEN_R      = r_live[2];
   assign oEN_G      = r_live[1];
   assign oEN_B      = r_live[0];
   assign oPENDING   = r_pending;
   assign oCOMMIT    = r_commit;
   assign oFRAME_CNT = r_frame_cnt;

endmodule

// File: tb/tb_filter_mode_ctrl.sv
// Directed bench for filter_mode_ctrl with a short debounce window; every
// expected value below is worked out by hand from the intended behaviour.
module tb_filter_mode_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [2:0] key_n;
   logic       vs;
   logic       stable;
   logic       en_r, en_g, en_b, pending, commit;
   logic [7:0] frame_cnt;
   logic [2:0] w_en;

   int n_vec  = 0;
   int n_fail = 0;
   int c;

   assign w_en = {en_r, en_g, en_b};

   filter_mode_ctrl #(
      .DEBOUNCE_CYCLES(4),
      .CNT_W          (3)
   ) dut (
      .iCLK      (clk),
      .iRST_N    (rst_n),
      .iKEY_N    (key_n),
      .iVGA_VS   (vs),
      .iTD_STABLE(stable),
      .oEN_R     (en_r),
      .oEN_G     (en_g),
      .oEN_B     (en_b),
      .oPENDING  (pending),
      .oCOMMIT   (commit),
      .oFRAME_CNT(frame_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press_key(input int idx, input int hold);
      key_n[idx] = 1'b0;
      tick(hold);
      key_n[idx] = 1'b1;
      tick(10);
   endtask

   task automatic vs_edge(output int commits);
      commits = 0;
      vs = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (commit) commits++;
      end
      vs = 1'b1;
      repeat (4) begin
         @(negedge clk);
         if (commit) commits++;
      end
   endtask

   initial begin
      rst_n  = 1'b0;
      key_n  = 3'b111;
      vs     = 1'b1;
      stable = 1'b1;
      tick(3);
      rst_n = 1'b1;
      tick(2);
      // Reset state
      check("rst_en",      32'(w_en),      32'b111);
      check("rst_pending", 32'(pending),   32'd0);
      check("rst_frame",   32'(frame_cnt), 32'd0);
      check("rst_commit",  32'(commit),    32'd0);

      // Red press, then exact commit latency after the VS edge
      key_n[2] = 1'b0;
      tick(10);
      check("red_pending_held", 32'(pending), 32'd1);
      key_n[2] = 1'b1;
      tick(10);
      check("red_pending", 32'(pending), 32'd1);
      check("red_en_pre",  32'(w_en),    32'b111);
      vs = 1'b0;
      tick(3);
      check("red_commit_early", 32'(commit), 32'd0);
      check("red_en_early",     32'(w_en),   32'b111);
      tick(1);
      check("red_commit", 32'(commit), 32'd1);
      check("red_en",     32'(w_en),   32'b011);
      tick(1);
      check("red_commit_off",  32'(commit),    32'd0);
      check("red_pending_off", 32'(pending),   32'd0);
      check("red_frame",       32'(frame_cnt), 32'd1);
      vs = 1'b1;
      tick(4);

      // Two green presses inside one frame cancel
      press_key(1, 6);
      check("grn1_pending", 32'(pending), 32'd1);
      press_key(1, 6);
      check("grn2_pending", 32'(pending), 32'd0);
      vs_edge(c);
      check("grn_commits", 32'(c),         32'd0);
      check("grn_en",      32'(w_en),      32'b011);
      check("grn_frame",   32'(frame_cnt), 32'd2);

      // Short glitches on blue are rejected, a 6-cycle hold is one toggle
      repeat (2) begin
         key_n[0] = 1'b0;
         tick(3);
         key_n[0] = 1'b1;
         tick(10);
      end
      check("glitch_pending", 32'(pending), 32'd0);
      check("glitch_en",      32'(w_en),    32'b011);
      press_key(0, 6);
      check("blue_pending", 32'(pending), 32'd1);
      vs_edge(c);
      check("blue_commits", 32'(c),         32'd1);
      check("blue_en",      32'(w_en),      32'b010);
      check("blue_frame",   32'(frame_cnt), 32'd3);
      check("blue_pending_off", 32'(pending), 32'd0);

      // Green press event lands in the vs_fall cycle while red is pending
      press_key(2, 6);
      check("coin_pending_pre", 32'(pending), 32'd1);
      key_n[1] = 1'b0;
      tick(4);
      vs = 1'b0;
      tick(2);
      key_n[1] = 1'b1;
      tick(2);
      check("coin_commit1", 32'(commit), 32'd1);
      check("coin_en1",     32'(w_en),   32'b110);
      tick(1);
      check("coin_commit1_off", 32'(commit), 32'd0);
      vs = 1'b1;
      tick(12);
      check("coin_pending_carry", 32'(pending),   32'd1);
      check("coin_en_hold",       32'(w_en),      32'b110);
      check("coin_frame1",        32'(frame_cnt), 32'd4);
      vs_edge(c);
      check("coin_commits2", 32'(c),         32'd1);
      check("coin_en2",      32'(w_en),      32'b100);
      check("coin_frame2",   32'(frame_cnt), 32'd5);
      check("coin_pending_off", 32'(pending), 32'd0);

      // Decoder unstable: forced pass-through, presses ignored, counter keeps running
      press_key(2, 6);
      check("unst_pending_pre", 32'(pending), 32'd1);
      stable = 1'b0;
      tick(1);
      check("unst_en",     32'(w_en),   32'b111);
      check("unst_commit", 32'(commit), 32'd1);
      tick(1);
      check("unst_commit_off", 32'(commit),  32'd0);
      check("unst_pending",    32'(pending), 32'd0);
      press_key(0, 6);
      check("unst_press_pending", 32'(pending), 32'd0);
      check("unst_press_en",      32'(w_en),    32'b111);
      c = 0;
      for (int i = 0; i < 251; i++) begin
         vs = 1'b0;
         repeat (3) begin
            @(negedge clk);
            if (commit) c++;
         end
         if (i == 249) check("wrap_255", 32'(frame_cnt), 32'd255);
         vs = 1'b1;
         repeat (3) begin
            @(negedge clk);
            if (commit) c++;
         end
      end
      check("wrap_0",       32'(frame_cnt), 32'd0);
      check("wrap_commits", 32'(c),         32'd0);
      stable = 1'b1;
      tick(2);
      check("resume_en",      32'(w_en),    32'b111);
      check("resume_pending", 32'(pending), 32'd0);
      press_key(1, 6);
      check("resume_press_pending", 32'(pending), 32'd1);
      vs_edge(c);
      check("resume_commits", 32'(c),         32'd1);
      check("resume_en2",     32'(w_en),      32'b101);
      check("resume_frame",   32'(frame_cnt), 32'd1);

      // Asynchronous reset while in COMMIT
      press_key(0, 6);
      vs = 1'b0;
      tick(3);
      check("arst_en_before", 32'(w_en), 32'b101);
      rst_n = 1'b0;
      #1;
      check("arst_en",      32'(w_en),      32'b111);
      check("arst_frame",   32'(frame_cnt), 32'd0);
      check("arst_pending", 32'(pending),   32'd0);
      check("arst_commit",  32'(commit),    32'd0);
      tick(1);
      check("arst_commit_hold", 32'(commit), 32'd0);
      vs = 1'b1;
      tick(2);
      rst_n = 1'b1;
      tick(3);
      check("arst_en_after",      32'(w_en),    32'b111);
      check("arst_pending_after", 32'(pending), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
